// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control FSM and its opcode decoder.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // One-hot instruction class; all-zero means unsupported.
  typedef struct packed {
    logic lw;
    logic sw;
    logic r;
    logic i;
    logic beq;
    logic jal;
  } op_class_t;

endpackage

// File: rtl/op_class_decoder.sv
// Combinational opcode classifier: class one-hot, immediate format, illegal flag.
module op_class_decoder
  import ctrl_pkg::*;
#(
  parameter int HAS_JAL   = 1,
  parameter int HAS_ITYPE = 1
) (
  input  logic [6:0] op,
  output op_class_t  cls,
  output logic [1:0] imm_src,
  output logic       illegal
);

  // Classify opcode; disabled classes leave the one-hot empty so they read as illegal.
  // ImmSrc follows the opcode's encoding format regardless of whether the class is enabled.
  always_comb begin
    cls     = '0;
    imm_src = IMM_I;
    case (op)
      OP_LW:  cls.lw = 1'b1;
      OP_SW:  begin cls.sw = 1'b1; imm_src = IMM_S; end
      OP_R:   cls.r = 1'b1;
      OP_I:   cls.i = (HAS_ITYPE != 0);
      OP_BEQ: begin cls.beq = 1'b1; imm_src = IMM_B; end
      OP_JAL: begin cls.jal = (HAS_JAL != 0); imm_src = IMM_J; end
      default: ;
    endcase
    illegal = (cls == '0);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for the multicycle RISC-V datapath.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int HAS_JAL       = 1,
  parameter int HAS_ITYPE     = 1,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       IllegalOp,
  output logic       Retire,
  output logic [3:0] State
);

  state_t     r_state;
  state_t     w_next;
  op_class_t  w_cls;
  logic [1:0] w_imm;
  logic       w_illegal;
  logic       w_rdy;

  op_class_decoder #(
    .HAS_JAL   (HAS_JAL),
    .HAS_ITYPE (HAS_ITYPE)
  ) u_dec (
    .op      (op),
    .cls     (w_cls),
    .imm_src (w_imm),
    .illegal (w_illegal)
  );

  // Without the handshake every memory access is treated as done in one cycle.
  assign w_rdy = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

  assign State = r_state;

  // State register; reset parks the FSM in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state: memory states hold until ready, DECODE dispatches on instruction class.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = w_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_cls.lw || w_cls.sw) w_next = S_MEMADR;
        else if (w_cls.r)         w_next = S_EXECR;
        else if (w_cls.i)         w_next = S_EXECI;
        else if (w_cls.beq)       w_next = S_BEQ;
        else if (w_cls.jal)       w_next = S_JAL;
        else                      w_next = S_FETCH;
      end
      S_MEMADR: begin
        if (w_cls.lw)      w_next = S_MEMREAD;
        else if (w_cls.sw) w_next = S_MEMWRITE;
        else               w_next = S_FETCH;
      end
      S_MEMREAD:  w_next = w_rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = w_rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  // Per-state control outputs; everything is forced low while reset is held.
  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALU_ADD;
    ResultSrc = RES_ALUOUT;
    ImmSrc    = IMM_I;
    IllegalOp = 1'b0;
    Retire    = 1'b0;
    if (rst_n) begin
      ImmSrc = w_imm;
      case (r_state)
        S_FETCH: begin
          MemReq    = 1'b1;
          ALUSrcA   = SRCA_PC;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURESULT;
          IRWrite   = w_rdy;
          PCWrite   = w_rdy;
        end
        S_DECODE: begin
          ALUSrcA   = SRCA_OLDPC;
          ALUSrcB   = SRCB_IMM;
          IllegalOp = w_illegal;
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMREAD: begin
          MemReq = 1'b1;
          AdrSrc = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = RES_DATA;
          RegWrite  = 1'b1;
          Retire    = 1'b1;
        end
        S_MEMWRITE: begin
          MemReq   = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
          Retire   = w_rdy;
        end
        S_EXECR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_RS2;
          ALUOp   = ALU_FUNCT;
        end
        S_EXECI: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_FUNCT;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          Retire   = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_RS2;
          ALUOp   = ALU_SUB;
          PCWrite = Zero;
          Retire  = 1'b1;
        end
        S_JAL: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller with a scoreboard queue of expected outputs.
module tb_multicycle_controller;
  import ctrl_pkg::*;

  // {State, MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite, SrcA, SrcB, ALUOp, Res, Imm, Ill, Ret}
  typedef struct packed {
    logic [3:0] st;
    logic [5:0] fl;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] alu;
    logic [1:0] res;
    logic [1:0] imm;
    logic       ill;
    logic       ret;
  } exp_t;

  typedef struct packed {
    logic [6:0] op;
    logic       z;
    logic       rdy;
    logic       rstn;
    exp_t       e;
  } vec_t;

  typedef struct {
    exp_t  e;
    bit    d2;
    string name;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] op = OP_LW;
  logic Zero = 1'b0;
  logic MemReady = 1'b1;

  logic m1_req, m1_wr, m1_adr, m1_irw, m1_pcw, m1_rw, m1_ill, m1_ret;
  logic [1:0] m1_a, m1_b, m1_alu, m1_res, m1_imm;
  logic [3:0] m1_st;
  logic m2_req, m2_wr, m2_adr, m2_irw, m2_pcw, m2_rw, m2_ill, m2_ret;
  logic [1:0] m2_a, m2_b, m2_alu, m2_res, m2_imm;
  logic [3:0] m2_st;

  exp_t act1, act2;
  assign act1 = {m1_st, m1_req, m1_wr, m1_adr, m1_irw, m1_pcw, m1_rw,
                 m1_a, m1_b, m1_alu, m1_res, m1_imm, m1_ill, m1_ret};
  assign act2 = {m2_st, m2_req, m2_wr, m2_adr, m2_irw, m2_pcw, m2_rw,
                 m2_a, m2_b, m2_alu, m2_res, m2_imm, m2_ill, m2_ret};

  always #5 clk = ~clk;

  multicycle_controller u_dut (
    .clk(clk), .rst_n(rst_n), .op(op), .Zero(Zero), .MemReady(MemReady),
    .MemReq(m1_req), .MemWrite(m1_wr), .AdrSrc(m1_adr), .IRWrite(m1_irw),
    .PCWrite(m1_pcw), .RegWrite(m1_rw), .ALUSrcA(m1_a), .ALUSrcB(m1_b),
    .ALUOp(m1_alu), .ResultSrc(m1_res), .ImmSrc(m1_imm), .IllegalOp(m1_ill),
    .Retire(m1_ret), .State(m1_st)
  );

  // Reduced build: no jal, no I-type, no memory handshake.
  multicycle_controller #(.HAS_JAL(0), .HAS_ITYPE(0), .MEM_HANDSHAKE(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .op(op), .Zero(Zero), .MemReady(MemReady),
    .MemReq(m2_req), .MemWrite(m2_wr), .AdrSrc(m2_adr), .IRWrite(m2_irw),
    .PCWrite(m2_pcw), .RegWrite(m2_rw), .ALUSrcA(m2_a), .ALUSrcB(m2_b),
    .ALUOp(m2_alu), .ResultSrc(m2_res), .ImmSrc(m2_imm), .IllegalOp(m2_ill),
    .Retire(m2_ret), .State(m2_st)
  );

  int n_cmp = 0;
  int n_err = 0;
  sb_t sb[$];
  vec_t tbl[$];
  vec_t tbl2[$];

  function automatic vec_t V(input logic [6:0] vop, input logic z, input logic rdy,
                             input logic rstn, input logic [3:0] st, input logic [5:0] fl,
                             input logic [1:0] a, input logic [1:0] b, input logic [1:0] alu,
                             input logic [1:0] res, input logic [1:0] imm,
                             input logic ill, input logic ret);
    vec_t v;
    v.op = vop; v.z = z; v.rdy = rdy; v.rstn = rstn;
    v.e = '{st: st, fl: fl, a: a, b: b, alu: alu, res: res, imm: imm, ill: ill, ret: ret};
    return v;
  endfunction

  task automatic check();
    sb_t  s;
    exp_t a;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
      return;
    end
    s = sb.pop_front();
    a = s.d2 ? act2 : act1;
    n_cmp++;
    if (a !== s.e) begin
      n_err++;
      $display("FAIL %s: got %h want %h (st %0d/%0d fl %b/%b)", s.name, a, s.e,
               a.st, s.e.st, a.fl, s.e.fl);
    end
  endtask

  // Apply one vector just after the edge, compare at the falling edge.
  task automatic drive(input vec_t v, input bit d2, input string name);
    @(posedge clk);
    #1;
    op = v.op; Zero = v.z; MemReady = v.rdy; rst_n = v.rstn;
    sb.push_back('{e: v.e, d2: d2, name: name});
    @(negedge clk);
    check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // op, z, rdy, rstn | st, {req,wr,adr,irw,pcw,rw}, A, B, ALUOp, Res, Imm, Ill, Ret
    tbl.push_back(V(OP_LW,0,1,0, 0,6'b000000, 0,0,0,0,0, 0,0)); // reset
    // lw, zero wait: 5 cycles
    tbl.push_back(V(OP_LW,0,1,1, 0,6'b100110, 0,2,0,2,0, 0,0));
    tbl.push_back(V(OP_LW,0,1,1, 1,6'b000000, 1,1,0,0,0, 0,0));
    tbl.push_back(V(OP_LW,0,1,1, 2,6'b000000, 2,1,0,0,0, 0,0));
    tbl.push_back(V(OP_LW,0,1,1, 3,6'b101000, 0,0,0,0,0, 0,0));
    tbl.push_back(V(OP_LW,0,1,1, 4,6'b000001, 0,0,0,1,0, 0,1));
    // sw, two wait cycles in MEMWRITE
    tbl.push_back(V(OP_SW,0,1,1, 0,6'b100110, 0,2,0,2,1, 0,0));
    tbl.push_back(V(OP_SW,0,1,1, 1,6'b000000, 1,1,0,0,1, 0,0));
    tbl.push_back(V(OP_SW,0,1,1, 2,6'b000000, 2,1,0,0,1, 0,0));
    tbl.push_back(V(OP_SW,0,0,1, 5,6'b111000, 0,0,0,0,1, 0,0));
    tbl.push_back(V(OP_SW,0,0,1, 5,6'b111000, 0,0,0,0,1, 0,0));
    tbl.push_back(V(OP_SW,0,1,1, 5,6'b111000, 0,0,0,0,1, 0,1));
    // beq taken
    tbl.push_back(V(OP_BEQ,1,1,1, 0,6'b100110, 0,2,0,2,2, 0,0));
    tbl.push_back(V(OP_BEQ,1,1,1, 1,6'b000000, 1,1,0,0,2, 0,0));
    tbl.push_back(V(OP_BEQ,1,1,1, 9,6'b000010, 2,0,1,0,2, 0,1));
    // beq not taken
    tbl.push_back(V(OP_BEQ,0,1,1, 0,6'b100110, 0,2,0,2,2, 0,0));
    tbl.push_back(V(OP_BEQ,0,1,1, 1,6'b000000, 1,1,0,0,2, 0,0));
    tbl.push_back(V(OP_BEQ,0,1,1, 9,6'b000000, 2,0,1,0,2, 0,1));
    // illegal opcode: 2 cycles
    tbl.push_back(V(7'h7F,0,1,1, 0,6'b100110, 0,2,0,2,0, 0,0));
    tbl.push_back(V(7'h7F,0,1,1, 1,6'b000000, 1,1,0,0,0, 1,0));
    // R-type with one fetch wait
    tbl.push_back(V(OP_R,0,0,1, 0,6'b100000, 0,2,0,2,0, 0,0));
    tbl.push_back(V(OP_R,0,1,1, 0,6'b100110, 0,2,0,2,0, 0,0));
    tbl.push_back(V(OP_R,0,1,1, 1,6'b000000, 1,1,0,0,0, 0,0));
    tbl.push_back(V(OP_R,0,1,1, 6,6'b000000, 2,0,2,0,0, 0,0));
    tbl.push_back(V(OP_R,0,1,1, 8,6'b000001, 0,0,0,0,0, 0,1));
    // I-type
    tbl.push_back(V(OP_I,0,1,1, 0,6'b100110, 0,2,0,2,0, 0,0));
    tbl.push_back(V(OP_I,0,1,1, 1,6'b000000, 1,1,0,0,0, 0,0));
    tbl.push_back(V(OP_I,0,1,1, 7,6'b000000, 2,1,2,0,0, 0,0));
    tbl.push_back(V(OP_I,0,1,1, 8,6'b000001, 0,0,0,0,0, 0,1));
    // jal
    tbl.push_back(V(OP_JAL,0,1,1, 0,6'b100110, 0,2,0,2,3, 0,0));
    tbl.push_back(V(OP_JAL,0,1,1, 1,6'b000000, 1,1,0,0,3, 0,0));
    tbl.push_back(V(OP_JAL,0,1,1, 10,6'b000010, 1,2,0,0,3, 0,0));
    tbl.push_back(V(OP_JAL,0,1,1, 8,6'b000001, 0,0,0,0,3, 0,1));
    // lw that will be aborted while stalled in MEMREAD
    tbl.push_back(V(OP_LW,0,1,1, 0,6'b100110, 0,2,0,2,0, 0,0));
    tbl.push_back(V(OP_LW,0,1,1, 1,6'b000000, 1,1,0,0,0, 0,0));
    tbl.push_back(V(OP_LW,0,1,1, 2,6'b000000, 2,1,0,0,0, 0,0));
    tbl.push_back(V(OP_LW,0,0,1, 3,6'b101000, 0,0,0,0,0, 0,0));

    // Reduced build: fetch ignores MemReady; jal and I-type are illegal.
    tbl2.push_back(V(OP_JAL,0,0,0, 0,6'b000000, 0,0,0,0,0, 0,0));
    tbl2.push_back(V(OP_JAL,0,0,1, 0,6'b100110, 0,2,0,2,3, 0,0));
    tbl2.push_back(V(OP_JAL,0,0,1, 1,6'b000000, 1,1,0,0,3, 1,0));
    tbl2.push_back(V(OP_I,0,0,1, 0,6'b100110, 0,2,0,2,0, 0,0));
    tbl2.push_back(V(OP_I,0,0,1, 1,6'b000000, 1,1,0,0,0, 1,0));
    tbl2.push_back(V(OP_I,0,0,1, 0,6'b100110, 0,2,0,2,0, 0,0));

    foreach (tbl[i]) drive(tbl[i], 1'b0, $sformatf("row%0d", i));

    // Reset mid-MEMREAD: outputs drop at once, without waiting for an edge.
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back('{e: exp_t'(0), d2: 1'b0, name: "abort_async"});
    check();
    drive(V(OP_LW,0,1,0, 0,6'b000000, 0,0,0,0,0, 0,0), 1'b0, "abort_held");
    drive(V(OP_LW,0,1,1, 0,6'b100110, 0,2,0,2,0, 0,0), 1'b0, "abort_refetch");
    drive(V(OP_LW,0,1,1, 1,6'b000000, 1,1,0,0,0, 0,0), 1'b0, "abort_decode");

    foreach (tbl2[i]) drive(tbl2[i], 1'b1, $sformatf("small%0d", i));

    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
